matrix_kbd_scan: RTL and testbench

Parametrised successor to the 4x4 LED-latch keypad reader. Scans an R x C key matrix, debounces full frames, and keeps a debounced key bitmap. Emits press and release events through a FIFO with a valid/ready handshake. Runs on the single system clock with an internal scan-tick enable, not a derived clock. Sits between the board keypad pins and any consumer (UART, LED or CPU glue).

---
 rtl/matrix_kbd_scan.sv | 189 ++++++++++++++++++
 tb/tb_matrix_kbd_scan.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_kbd_scan.sv
// Row-scanned R x C key matrix reader with frame debounce, key bitmap and press/release event FIFO.
// Optional build macro KBD_GHOST_REJECT_EN rejects frames containing a pressed-key rectangle.
module matrix_kbd_scan #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int SCAN_FREQ  = 1000,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [COLS-1:0]               column_i,
  output logic [ROWS-1:0]               row_o,
  output logic [ROWS*COLS-1:0]          keys_o,
  output logic                          key_valid_o,
  input  logic                          key_ready_i,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code_o,
  output logic                          key_press_o,
  output logic                          overflow_o
);

  localparam int N      = ROWS * COLS;
  localparam int TICK   = CLK_FREQ / SCAN_FREQ;
  localparam int TICK_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int CODE_W = $clog2(N);
  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE - 1);

  if (TICK < N + 2 || ROWS < 2 || COLS < 2 || DEBOUNCE < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("matrix_kbd_scan: illegal parameters (TICK must be >= ROWS*COLS+2)");
  end

  typedef struct packed {
    logic              press;
    logic [CODE_W-1:0] code;
  } evt_t;

  typedef enum logic {S_IDLE, S_EMIT} emit_state_e;

  logic [TICK_W-1:0] r_tick;
  logic [ROW_W-1:0]  r_row;
  logic [N-1:0]      r_raw, r_prev, r_keys, r_changed;
  logic [DB_W-1:0]   r_stable;
  logic              r_commit;

  logic              w_tick_end, w_frame_end, w_ambiguous;
  logic [N-1:0]      w_raw_next;
  logic [DB_W-1:0]   w_stable_next;

  assign w_tick_end  = (r_tick == TICK_W'(TICK - 1));
  assign w_frame_end = w_tick_end && (r_row == ROW_W'(ROWS - 1));
  assign row_o       = ~(ROWS'(1) << r_row);
  assign keys_o      = r_keys;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_raw_next = r_raw;
    w_raw_next[r_row*COLS +: COLS] = ~column_i;
  end

`ifdef KBD_GHOST_REJECT_EN
  // A rectangle of closed keys makes the fourth corner indistinguishable from a real press.
  function automatic logic frame_ambiguous(input logic [N-1:0] f);
    logic amb;
    int   shared;
    amb = 1'b0;
    for (int a = 0; a < ROWS; a++) begin
      for (int b = a + 1; b < ROWS; b++) begin
        shared = 0;
        for (int c = 0; c < COLS; c++) begin
          if (f[a*COLS+c] && f[b*COLS+c]) shared++;
        end
        if (shared >= 2) amb = 1'b1;
      end
    end
    return amb;
  endfunction

  assign w_ambiguous = frame_ambiguous(w_raw_next);
`else
  assign w_ambiguous = 1'b0;
`endif

  always_comb begin
    w_stable_next = '0;
    if (w_raw_next == r_prev && !w_ambiguous)
      w_stable_next = (r_stable == DB_MAX) ? r_stable : r_stable + DB_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tick    <= '0;
      r_row     <= '0;
      r_raw     <= '0;
      r_prev    <= '0;
      r_stable  <= '0;
      r_keys    <= '0;
      r_changed <= '0;
      r_commit  <= 1'b0;
    end else begin
      r_tick <= w_tick_end ? '0 : r_tick + TICK_W'(1);
      if (w_tick_end) begin
        r_raw <= w_raw_next;
        r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
      end
      if (w_frame_end) begin
        r_prev   <= w_raw_next;
        r_stable <= w_stable_next;
      end
      r_commit <= w_frame_end && !w_ambiguous && (w_stable_next == DB_MAX) && (w_raw_next != r_keys);
      // r_raw is untouched until the next row-0 sample, so it still holds the committed frame.
      if (r_commit) begin
        r_keys    <= r_raw;
        r_changed <= r_raw ^ r_keys;
      end
    end
  end

  emit_state_e       r_state, w_state_next;
  logic [CODE_W-1:0] r_idx;
  logic              w_push;
  evt_t              w_push_evt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= (r_state == S_EMIT && w_state_next == S_EMIT) ? r_idx + CODE_W'(1) : '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (r_commit) w_state_next = S_EMIT;
      S_EMIT:  if (r_idx == CODE_W'(N - 1)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_push           = (r_state == S_EMIT) && r_changed[r_idx];
    w_push_evt.press = r_keys[r_idx];
    w_push_evt.code  = r_idx;
  end

  evt_t           r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr, r_rd_ptr;
  logic           r_overflow;
  logic           w_empty, w_full, w_pop, w_wr_en;
  evt_t           w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && key_ready_i;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

  assign key_valid_o = !w_empty;
  assign key_code_o  = w_empty ? '0 : w_head.code;
  assign key_press_o = !w_empty && w_head.press;
  assign overflow_o  = r_overflow;

  // NOTE: storage is not reset; the pointers define which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_evt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_kbd_scan.sv
// Scoreboard bench for matrix_kbd_scan: a resistive key-matrix model with ghosting drives column_i.
// Honours KBD_GHOST_REJECT_EN for the ghost scenario.
module tb_matrix_kbd_scan;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  column_i;
  logic [3:0]  row_o;
  logic [15:0] keys_o;
  logic        key_valid_o;
  logic        key_ready_i;
  logic [3:0]  key_code_o;
  logic        key_press_o;
  logic        overflow_o;

  logic [15:0] closed;
  logic [4:0]  sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  matrix_kbd_scan #(
    .CLK_FREQ(200), .SCAN_FREQ(10), .ROWS(4), .COLS(4), .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .column_i(column_i), .row_o(row_o), .keys_o(keys_o),
    .key_valid_o(key_valid_o), .key_ready_i(key_ready_i), .key_code_o(key_code_o),
    .key_press_o(key_press_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Columns reachable from driven row r through closed switches (sneak paths produce ghosts).
  function automatic logic [3:0] sense(input int r, input logic [15:0] m);
    logic [3:0] cols;
    cols = m[r*4 +: 4];
    for (int k = 0; k < 4; k++)
      for (int r2 = 0; r2 < 4; r2++)
        if (|(cols & m[r2*4 +: 4])) cols = cols | m[r2*4 +: 4];
    return cols;
  endfunction

  always_comb begin
    column_i = '1;
    for (int r = 0; r < 4; r++)
      if (!row_o[r]) column_i = ~sense(r, closed);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer side of the scoreboard: every accepted event must match the queue head.
  always @(negedge clk_i) begin
    if (!rst_i && key_valid_o && key_ready_i) begin
      if (sb_q.size() == 0) check("unexpected_evt", {27'd0, key_press_o, key_code_o}, 32'h1ff);
      else check("evt", {27'd0, key_press_o, key_code_o}, {27'd0, sb_q.pop_front()});
    end
  end

  task automatic wait_keys(input logic [15:0] exp, input int budget, input string tag);
    int n = 0;
    while (keys_o !== exp && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, keys_o, exp);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || key_valid_o) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, sb_q.size(), 0);
  endtask

  task automatic set_keys(input logic [15:0] m);
    @(posedge clk_i);
    #1 closed = m;
  endtask

  initial begin
    rst_i = 1'b1;
    key_ready_i = 1'b1;
    closed = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    closed = 16'h0200;
    sb_q.push_back({1'b1, 4'd9});
    @(negedge clk_i);
    check("rst_row", row_o, 4'b1110);
    check("rst_keys", keys_o, 16'h0);
    check("rst_valid", key_valid_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    repeat (19) @(posedge clk_i);
    @(negedge clk_i);
    check("row_hold", row_o, 4'b1110);
    @(posedge clk_i);
    @(negedge clk_i);
    check("row_step", row_o, 4'b1101);
    repeat (220) @(posedge clk_i);
    @(negedge clk_i);
    check("press_early", keys_o[9], 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("press_lat", keys_o, 16'h0200);
    drain("press_drain");

    set_keys(16'h0);
    sb_q.push_back({1'b0, 4'd9});
    wait_keys(16'h0, 600, "release_keys");
    drain("release_drain");

    set_keys(16'h0020);
    repeat (80) @(posedge clk_i);
    #1 closed = 16'h0;
    repeat (400) @(negedge clk_i);
    check("bounce_keys", keys_o, 16'h0);
    check("bounce_valid", key_valid_o, 1'b0);

    set_keys(16'h8001);
    sb_q.push_back({1'b1, 4'd0});
    sb_q.push_back({1'b1, 4'd15});
    wait_keys(16'h8001, 600, "dual_keys");
    drain("dual_drain");
    set_keys(16'h0);
    sb_q.push_back({1'b0, 4'd0});
    sb_q.push_back({1'b0, 4'd15});
    wait_keys(16'h0, 600, "dual_rel_keys");
    drain("dual_rel_drain");

    key_ready_i = 1'b0;
    set_keys(16'h000f);
    for (int i = 0; i < 4; i++) sb_q.push_back({1'b1, 4'(i)});
    wait_keys(16'h000f, 600, "full_keys");
    repeat (20) @(negedge clk_i);
    check("full_noovf", overflow_o, 1'b0);
    check("full_valid", key_valid_o, 1'b1);
    check("full_head", key_code_o, 4'd0);
    repeat (5) @(negedge clk_i);
    check("head_hold", {key_press_o, key_code_o}, {1'b1, 4'd0});
    set_keys(16'h0007);
    wait_keys(16'h0007, 600, "drop_keys");
    repeat (20) @(negedge clk_i);
    check("ovf_set", overflow_o, 1'b1);
    check("ovf_head", key_code_o, 4'd0);
    @(posedge clk_i);
    #1 key_ready_i = 1'b1;
    drain("ovf_drain");
    check("ovf_empty", key_valid_o, 1'b0);
    check("ovf_sticky", overflow_o, 1'b1);

    @(posedge clk_i);
    #1 closed = 16'h0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    sb_q.delete();
    @(negedge clk_i);
    check("rst2_ovf", overflow_o, 1'b0);
    check("rst2_keys", keys_o, 16'h0);
    check("rst2_valid", key_valid_o, 1'b0);

    set_keys(16'h0013);
`ifdef KBD_GHOST_REJECT_EN
    repeat (480) @(negedge clk_i);
    check("ghost_keys", keys_o, 16'h0);
    check("ghost_valid", key_valid_o, 1'b0);
`else
    sb_q.push_back({1'b1, 4'd0});
    sb_q.push_back({1'b1, 4'd1});
    sb_q.push_back({1'b1, 4'd4});
    sb_q.push_back({1'b1, 4'd5});
    wait_keys(16'h0033, 600, "ghost_keys");
    drain("ghost_drain");
`endif
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
